// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector's x input.
// One-word holding register behind a valid/ready handshake allows gapless streaming.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | nothing being shifted; x parked at IDLE_BIT
// ST_SHIFT | word in sh being shifted out; cnt = index of bit currently on x
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_active,
  output logic             frame_done
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [CW-1:0]    cnt;

  logic accept;
  logic load;
  logic last_bit;
  logic hold_first;
  logic sh_next_bit;

  assign din_ready   = nrst & ~hold_valid;
  assign accept      = din_valid & din_ready;
  assign last_bit    = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign load        = hold_valid & ((state == ST_IDLE) | last_bit);
  assign hold_first  = MSB_FIRST ? hold[WIDTH-1] : hold[0];
  assign sh_next_bit = MSB_FIRST ? sh[WIDTH-2]   : sh[1];

  // accept and load are mutually exclusive: one needs hold empty, the other full
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold       <= din;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sh <= hold;
    end else if (state == ST_SHIFT) begin
      if (MSB_FIRST) sh <= {sh[WIDTH-2:0], 1'b0};
      else           sh <= {1'b0, sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      x          <= IDLE_BIT;
      x_active   <= 1'b0;
      frame_done <= 1'b0;
    end else if (load) begin
      state      <= ST_SHIFT;
      cnt        <= '0;
      x          <= hold_first;
      x_active   <= 1'b1;
      frame_done <= 1'b0;
    end else if (state == ST_SHIFT) begin
      if (cnt == CNT_LAST) begin
        state      <= ST_IDLE;
        cnt        <= '0;
        x          <= IDLE_BIT;
        x_active   <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        cnt        <= cnt + CNT_ONE;
        x          <= sh_next_bit;
        x_active   <= 1'b1;
        // registered so the pulse lines up with the last bit on x
        frame_done <= (cnt == CNT_PEN);
      end
    end
  end

endmodule
